// File: rtl/voice_allocator.sv
// voice_allocator: schedules note events onto PIPELINE_COUNT voices and steals the oldest when full.
// Optional feature macro VOICE_SUSTAIN_EN adds a sustain-pedal input that defers note-off releases.
module voice_allocator #(
   parameter int unsigned PIPELINE_COUNT = 4,
   parameter int unsigned NOTE_WIDTH     = 7,
   parameter int unsigned VEL_WIDTH      = 7
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
`ifdef VOICE_SUSTAIN_EN
   input  logic                                      sustain,
`endif
   input  logic                                      note_valid,
   output logic                                      note_ready,
   input  logic                                      note_on,
   input  logic [NOTE_WIDTH-1:0]                     note_num,
   input  logic [VEL_WIDTH-1:0]                      note_vel,
   output logic [PIPELINE_COUNT-1:0]                 voice_active,
   output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0] voice_note,
   output logic [PIPELINE_COUNT-1:0][VEL_WIDTH-1:0]  voice_vel,
   output logic [PIPELINE_COUNT-1:0]                 voice_trigger,
   output logic [PIPELINE_COUNT-1:0]                 voice_release,
   output logic                                      voice_stolen
);

   localparam int unsigned AW = $clog2(PIPELINE_COUNT);
   localparam int PcInt = int'(PIPELINE_COUNT);

   typedef enum logic {StIdle, StAlloc} state_e;

   state_e state_q, state_d;

   logic                                      ev_on_q, ev_on_d;
   logic [NOTE_WIDTH-1:0]                     ev_num_q, ev_num_d;
   logic [VEL_WIDTH-1:0]                      ev_vel_q, ev_vel_d;
   logic [PIPELINE_COUNT-1:0]                 active_q, active_d;
   logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0] note_q, note_d;
   logic [PIPELINE_COUNT-1:0][VEL_WIDTH-1:0]  vel_q, vel_d;
   logic [PIPELINE_COUNT-1:0][AW-1:0]         age_q, age_d;
   logic [PIPELINE_COUNT-1:0]                 trig_q, trig_d;
   logic [PIPELINE_COUNT-1:0]                 rel_q, rel_d;
   logic                                      stolen_q, stolen_d;

   logic [PIPELINE_COUNT-1:0] hit;
   logic                      hit_any, free_any, steal, is_on, used;
   logic [AW-1:0]             hit_idx, free_idx, old_idx, sel, gap, limit;

`ifdef VOICE_SUSTAIN_EN
   logic                      sus_q, sus_prev_q;
   logic [PIPELINE_COUNT-1:0] sust_q, sust_d, pedal_rel;
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (note_valid && note_ready) state_d = StAlloc;
         StAlloc: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      note_ready = (state_q == StIdle);
   end

   // Voice selection for the latched event
   always_comb begin
      is_on    = ev_on_q && (ev_vel_q != '0);
      hit      = '0;
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      old_idx  = '0;
      gap      = '0;
      used     = 1'b0;
      for (int i = PcInt - 1; i >= 0; i--) begin
         hit[i] = active_q[i] && (note_q[i] == ev_num_q);
         if (hit[i]) begin
            hit_any = 1'b1;
            hit_idx = AW'(i);
         end
         if (!active_q[i]) begin
            free_any = 1'b1;
            free_idx = AW'(i);
         end
      end
      for (int i = 1; i < PcInt; i++) begin
         if (age_q[i] > age_q[old_idx]) old_idx = AW'(i);
      end
      // Lowest age value not held by any active voice
      for (int g = PcInt - 1; g >= 0; g--) begin
         used = 1'b0;
         for (int j = 0; j < PcInt; j++) begin
            if (active_q[j] && (age_q[j] == AW'(g))) used = 1'b1;
         end
         if (!used) gap = AW'(g);
      end
      steal = !hit_any && !free_any;
      sel   = hit_any ? hit_idx : (free_any ? free_idx : old_idx);
      // A fresh voice bumps only ages below the lowest unused one: same ordering as bumping
      // every active voice, but released voices leave gaps that would otherwise overflow.
      limit = active_q[sel] ? age_q[sel] : gap;
   end

   // Event latch and voice state next-state
   always_comb begin
      ev_on_d  = ev_on_q;
      ev_num_d = ev_num_q;
      ev_vel_d = ev_vel_q;
      active_d = active_q;
      note_d   = note_q;
      vel_d    = vel_q;
      age_d    = age_q;
      trig_d   = '0;
      rel_d    = '0;
      stolen_d = 1'b0;
`ifdef VOICE_SUSTAIN_EN
      sust_d    = sust_q;
      pedal_rel = '0;
`endif
      if (note_valid && note_ready) begin
         ev_on_d  = note_on;
         ev_num_d = note_num;
         ev_vel_d = note_vel;
      end
      if (state_q == StAlloc) begin
         if (is_on) begin
            for (int j = 0; j < PcInt; j++) begin
               if ((AW'(j) != sel) && active_q[j] && (age_q[j] < limit)) begin
                  age_d[j] = age_q[j] + AW'(1);
               end
            end
            age_d[sel]    = '0;
            active_d[sel] = 1'b1;
            note_d[sel]   = ev_num_q;
            vel_d[sel]    = ev_vel_q;
            trig_d[sel]   = 1'b1;
            stolen_d      = steal;
`ifdef VOICE_SUSTAIN_EN
            sust_d[sel]   = 1'b0;
`endif
         end else begin
`ifdef VOICE_SUSTAIN_EN
            if (sus_q) begin
               sust_d = sust_q | hit;
            end else begin
               rel_d    = hit;
               active_d = active_q & ~hit;
               sust_d   = sust_q & ~hit;
            end
`else
            rel_d    = hit;
            active_d = active_q & ~hit;
`endif
         end
      end
`ifdef VOICE_SUSTAIN_EN
      // Pedal lift releases held voices, sparing one just retriggered in the same edge
      if (sus_prev_q && !sus_q) begin
         pedal_rel = sust_q & active_q & ~trig_d;
         rel_d     = rel_d | pedal_rel;
         active_d  = active_d & ~pedal_rel;
         sust_d    = sust_d & ~pedal_rel;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_on_q  <= 1'b0;
         ev_num_q <= '0;
         ev_vel_q <= '0;
         active_q <= '0;
         note_q   <= '0;
         vel_q    <= '0;
         age_q    <= '0;
         trig_q   <= '0;
         rel_q    <= '0;
         stolen_q <= 1'b0;
      end else begin
         ev_on_q  <= ev_on_d;
         ev_num_q <= ev_num_d;
         ev_vel_q <= ev_vel_d;
         active_q <= active_d;
         note_q   <= note_d;
         vel_q    <= vel_d;
         age_q    <= age_d;
         trig_q   <= trig_d;
         rel_q    <= rel_d;
         stolen_q <= stolen_d;
      end
   end

`ifdef VOICE_SUSTAIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sus_q      <= 1'b0;
         sus_prev_q <= 1'b0;
         sust_q     <= '0;
      end else begin
         sus_q      <= sustain;
         sus_prev_q <= sus_q;
         sust_q     <= sust_d;
      end
   end
`endif

   assign voice_active  = active_q;
   assign voice_note    = note_q;
   assign voice_vel     = vel_q;
   assign voice_trigger = trig_q;
   assign voice_release = rel_q;
   assign voice_stolen  = stolen_q;

endmodule
